id_fetch_queue: RTL

ID_FETCH_QUEUE -- requirements
Module: id_fetch_queue

---
 rtl/id_fetch_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/id_fetch_queue.sv
// rtl/id_fetch_queue.sv - IF/ID decoupling queue with optional JAL redirect (ID_JUMP_REDIRECT_EN)
module id_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_if_valid,
    input  logic [31:0]                i_if_instr,
    input  logic [63:0]                i_if_pc,
    output logic                       o_id_ready,
    output logic                       o_is_jump,
    output logic [63:0]                o_id_PC,
    input  logic                       i_flush,
    output logic                       o_dec_valid,
    output logic [31:0]                o_dec_instr,
    output logic [63:0]                o_dec_pc,
    input  logic                       i_dec_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [6:0]    OP_JAL   = 7'b110_1111;

    logic [31:0]   instr_mem [DEPTH];
    logic [63:0]   pc_mem    [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    assign o_id_ready  = rst_n && (count_q != FULL_CNT) && !i_flush;
    assign push        = i_if_valid && o_id_ready;
    assign o_dec_valid = (count_q != '0);
    assign pop         = o_dec_valid && i_dec_ready;

    assign o_dec_instr = o_dec_valid ? instr_mem[rd_ptr_q] : NOP;
    assign o_dec_pc    = o_dec_valid ? pc_mem[rd_ptr_q]    : 64'd0;
    assign o_count     = count_q;

    // Flush overrides push and pop; push is already blocked by o_id_ready.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= i_if_instr;
            pc_mem[wr_ptr_q]    <= i_if_pc;
        end
    end

`ifdef ID_JUMP_REDIRECT_EN
    logic        is_jal;
    logic [63:0] j_imm;

    assign is_jal    = push && (i_if_instr[6:0] == OP_JAL);
    assign j_imm     = {{43{i_if_instr[31]}}, i_if_instr[31], i_if_instr[19:12],
                        i_if_instr[20], i_if_instr[30:21], 1'b0};
    assign o_is_jump = is_jal;
    assign o_id_PC   = is_jal ? (i_if_pc + j_imm) : 64'd0;
`else
    // JAL resolves in EX like any other branch in this build.
    assign o_is_jump = 1'b0;
    assign o_id_PC   = 64'd0;
`endif

endmodule
